// File: rtl/debounced_input_sampler_if.sv
// debounced_input_sampler_if
//   Masked write port from the input sampler to the downstream status register
//   (through its clock-domain crossing).
//   IO_WrData  write data, held between writes
//   IO_WrMask  write mask, 1 = bit updated
//   IO_WrEn    one-cycle write strobe
//   IO_Busy    downstream transfer in progress
//   master: the sampler side; slave: the register / crossing side.
interface debounced_input_sampler_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] IO_WrData;
    logic [DATA_WIDTH-1:0] IO_WrMask;
    logic                  IO_WrEn;
    logic                  IO_Busy;

    modport master (
        output IO_WrData,
        output IO_WrMask,
        output IO_WrEn,
        input  IO_Busy
    );

    modport slave (
        input  IO_WrData,
        input  IO_WrMask,
        input  IO_WrEn,
        output IO_Busy
    );
endinterface

// File: rtl/debounced_input_sampler.sv
// debounced_input_sampler
//   Synchronizes and debounces each raw input bit, accumulates the bits whose
//   debounced value changed, and pushes them to a read-only status register as a
//   masked write whenever the downstream crossing is free.
//   IO_Clock      I/O-domain clock (only clock)
//   IO_Reset      asynchronous active-high reset
//   Pin_In        raw asynchronous inputs
//   Stable_State  debounced input value
//   wr            masked write port (IO_WrData/IO_WrMask/IO_WrEn out, IO_Busy in)
module debounced_input_sampler #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int unsigned           SYNC_STAGES     = 2,
    parameter int unsigned           DEBOUNCE_CYCLES = 16
) (
    input  logic                      IO_Clock,
    input  logic                      IO_Reset,
    input  logic [DATA_WIDTH-1:0]     Pin_In,
    output logic [DATA_WIDTH-1:0]     Stable_State,
    debounced_input_sampler_if.master wr
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGuard,
        StWait
    } state_e;

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_last;
    logic [CNT_W-1:0]      cnt_q [DATA_WIDTH];
    logic [CNT_W-1:0]      cnt_d [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] stable_q;
    logic [DATA_WIDTH-1:0] stable_d;
    logic [DATA_WIDTH-1:0] toggle;
    logic [DATA_WIDTH-1:0] pending_q;
    state_e                state_q;

    // Synchronizer chain
    always_ff @(posedge IO_Clock or posedge IO_Reset) begin
        if (IO_Reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= Pin_In;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Per-bit debounce: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive samples that differ from the current stable value.
    always_comb begin
        stable_d = stable_q;
        toggle   = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_last[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync_last[i];
                    toggle[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge IO_Clock or posedge IO_Reset) begin
        if (IO_Reset) begin
            stable_q <= RESET_VALUE;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign Stable_State = stable_q;

    // Write FSM with registered outputs. GUARD ignores Busy for one cycle so a
    // downstream that raises Busy one cycle after the strobe is not overrun.
    always_ff @(posedge IO_Clock or posedge IO_Reset) begin
        if (IO_Reset) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            wr.IO_WrEn   <= 1'b0;
            wr.IO_WrData <= RESET_VALUE;
            wr.IO_WrMask <= '0;
        end else begin
            wr.IO_WrEn <= 1'b0;
            pending_q  <= pending_q | toggle;
            unique case (state_q)
                StIdle: begin
                    if ((pending_q != '0) && !wr.IO_Busy) begin
                        wr.IO_WrEn   <= 1'b1;
                        wr.IO_WrData <= stable_q;
                        wr.IO_WrMask <= pending_q;
                        // Bits toggling on the issue edge stay pending
                        pending_q    <= toggle;
                        state_q      <= StGuard;
                    end
                end
                StGuard: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (!wr.IO_Busy) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounced_input_sampler.sv
module tb_debounced_input_sampler;

    localparam int W  = 32;
    localparam int SS = 2;
    localparam int DC = 16;
    localparam logic [W-1:0] RV = '0;

    logic         io_clock;
    logic         io_reset;
    logic [W-1:0] pin_in;
    logic [W-1:0] stable_state;

    debounced_input_sampler_if #(.DATA_WIDTH(W)) bus ();

    debounced_input_sampler #(
        .DATA_WIDTH      (W),
        .RESET_VALUE     (RV),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .IO_Clock     (io_clock),
        .IO_Reset     (io_reset),
        .Pin_In       (pin_in),
        .Stable_State (stable_state),
        .wr           (bus)
    );

    initial io_clock = 1'b0;
    always #5 io_clock = ~io_clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle time %0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_sync[$];   // pin words in flight, index 0 newest
    logic [W-1:0] m_seen[$];   // last DC synchronized samples, newest at back
    logic [W-1:0] m_stable, m_pending, m_wr_data, m_wr_mask;
    logic         m_wr_en;
    int           m_phase;     // 0 ready, 1 just strobed, 2 waiting for Busy low

    task automatic model_reset();
        m_sync.delete();
        m_seen.delete();
        for (int s = 0; s < SS; s++) m_sync.push_back(RV);
        for (int s = 0; s < DC; s++) m_seen.push_back(RV);
        m_stable  = RV;
        m_pending = '0;
        m_wr_data = RV;
        m_wr_mask = '0;
        m_wr_en   = 1'b0;
        m_phase   = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] pin, input logic busy);
        logic [W-1:0] new_stable;
        logic [W-1:0] tog;
        logic         all_diff;
        m_seen.push_back(m_sync[SS-1]);
        void'(m_seen.pop_front());
        new_stable = m_stable;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (m_seen[j]) if (m_seen[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) new_stable[b] = ~m_stable[b];
        end
        tog     = new_stable ^ m_stable;
        m_wr_en = 1'b0;
        if (m_phase == 0 && m_pending != '0 && !busy) begin
            m_wr_en   = 1'b1;
            m_wr_data = m_stable;
            m_wr_mask = m_pending;
            m_pending = tog;
            m_phase   = 1;
        end else begin
            m_pending = m_pending | tog;
            if (m_phase == 1) m_phase = 2;
            else if (m_phase == 2 && !busy) m_phase = 0;
        end
        m_stable = new_stable;
        m_sync.push_front(pin);
        void'(m_sync.pop_back());
    endtask

    // ---------------- stimulus driver ----------------
    logic [W-1:0] pin;
    logic         rst;
    logic         busy_force;
    int           busy_len;
    int           busy_cnt;
    int           cycle;
    logic [W-1:0] str_mask[$];
    logic [W-1:0] str_data[$];
    int           str_cyc[$];

    task automatic compare_all(input string tag);
        check_eq({tag, ".stable"}, stable_state,  m_stable);
        check_eq({tag, ".wr_en"},  bus.IO_WrEn,   m_wr_en);
        check_eq({tag, ".wr_data"}, bus.IO_WrData, m_wr_data);
        check_eq({tag, ".wr_mask"}, bus.IO_WrMask, m_wr_mask);
    endtask

    task automatic step();
        logic busy_now;
        @(negedge io_clock);
        busy_now = busy_force || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        pin_in      = pin;
        bus.IO_Busy = busy_now;
        io_reset    = rst;
        if (rst) begin
            model_reset();
            #1 compare_all("rst_async");
        end else begin
            model_edge(pin, busy_now);
        end
        @(posedge io_clock);
        #1;
        compare_all("cyc");
        if (bus.IO_WrEn) begin
            check_eq("busy_at_issue", {31'd0, busy_now}, '0);
            str_mask.push_back(bus.IO_WrMask);
            str_data.push_back(bus.IO_WrData);
            str_cyc.push_back(cycle);
            if (busy_len > 0) busy_cnt = busy_len;
        end
        cycle++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_strobes();
        str_mask.delete();
        str_data.delete();
        str_cyc.delete();
    endtask

    initial begin
        rst         = 1'b1;
        pin         = '1;
        busy_force  = 1'b0;
        busy_len    = 0;
        busy_cnt    = 0;
        cycle       = 0;
        io_reset    = 1'b1;
        pin_in      = '1;
        bus.IO_Busy = 1'b0;
        model_reset();

        // Reset with all pins high, then release
        run(3);
        check_eq("reset.wr_en", bus.IO_WrEn, '0);
        check_eq("reset.stable", stable_state, RV);
        clear_strobes();
        rst = 1'b0;
        run(25);
        check_eq("reset.n_strobe", str_mask.size(), 1);
        if (str_mask.size() == 1) begin
            check_eq("reset.mask", str_mask[0], 32'hFFFF_FFFF);
            check_eq("reset.data", str_data[0], 32'hFFFF_FFFF);
        end

        // Back to all-low baseline through reset
        pin = '0;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(5);

        // Glitch of 15 samples rejected, 16 accepted
        clear_strobes();
        pin[3] = 1'b1;
        run(15);
        pin[3] = 1'b0;
        run(30);
        check_eq("glitch15.n_strobe", str_mask.size(), 0);
        check_eq("glitch15.stable", stable_state, 32'h0);
        pin[3] = 1'b1;
        run(16);
        run(10);
        check_eq("hold16.n_strobe", str_mask.size(), 1);
        if (str_mask.size() == 1) begin
            check_eq("hold16.mask", str_mask[0], 32'h0000_0008);
            check_eq("hold16.data", str_data[0], 32'h0000_0008);
        end

        // Coalescing while Busy is held
        clear_strobes();
        busy_force = 1'b1;
        pin[0] = 1'b1;
        run(4);
        pin[5] = 1'b1;
        run(7);
        pin[31] = 1'b1;
        run(30);
        check_eq("coalesce.none_busy", str_mask.size(), 0);
        busy_force = 1'b0;
        run(10);
        check_eq("coalesce.n_strobe", str_mask.size(), 1);
        if (str_mask.size() == 1) begin
            check_eq("coalesce.mask", str_mask[0], 32'h8000_0021);
            check_eq("coalesce.data", str_data[0], 32'h8000_0029);
        end

        // Bit 1 toggles on the issue edge of the bit 0 write
        clear_strobes();
        pin[0] = 1'b0;
        run(1);
        pin[1] = 1'b1;
        run(30);
        check_eq("same_edge.n_strobe", str_mask.size(), 2);
        if (str_mask.size() == 2) begin
            check_eq("same_edge.mask0", str_mask[0], 32'h1);
            check_eq("same_edge.mask1", str_mask[1], 32'h2);
            check_eq("same_edge.gap", str_cyc[1] - str_cyc[0], 3);
        end

        // Downstream raises Busy after each strobe for 10 cycles
        clear_strobes();
        busy_len = 10;
        pin[2] = 1'b1;
        run(5);
        pin[4] = 1'b1;
        run(40);
        check_eq("handshake.n_strobe", str_mask.size(), 2);
        if (str_mask.size() == 2) begin
            check_eq("handshake.mask0", str_mask[0], 32'h4);
            check_eq("handshake.mask1", str_mask[1], 32'h10);
            check_eq("handshake.gap", str_cyc[1] - str_cyc[0], 12);
        end
        busy_len = 0;
        run(15);

        // Reset while a change is pending behind Busy
        clear_strobes();
        busy_force = 1'b1;
        pin[4] = 1'b0;
        run(25);
        check_eq("midrst.none_busy", str_mask.size(), 0);
        rst = 1'b1;
        pin = '0;
        run(2);
        rst = 1'b0;
        busy_force = 1'b0;
        run(30);
        check_eq("midrst.n_strobe", str_mask.size(), 0);
        check_eq("midrst.stable", stable_state, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            int b;
            r = $urandom_range(0, 999);
            if (r < 30) begin
                pin = $urandom();
            end else if (r < 120) begin
                b = $urandom_range(0, W - 1);
                pin[b] = ~pin[b];
            end
            if ($urandom_range(0, 199) == 0) busy_len = $urandom_range(0, 6);
            if (!busy_force && $urandom_range(0, 149) == 0) busy_force = 1'b1;
            else if (busy_force && $urandom_range(0, 29) == 0) busy_force = 1'b0;
            rst = ($urandom_range(0, 699) == 0) || (rst && $urandom_range(0, 1) == 0);
            step();
        end
        rst = 1'b0;
        busy_force = 1'b0;
        run(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
